sram_port_arbiter: RTL

//  Shares the single 16-bit asynchronous external SRAM between two 32-bit requesters: port 0 (instruction fetch, read-only) and port 1 (data, read/write).

---
 rtl/sram_port_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for a 16-bit asynchronous SRAM. Each 32-bit access is
// split into two beats (upper halfword at the even address, then the lower
// halfword at +1), with a req/ack handshake towards both requesters.
// All SRAM pins are registered so strobes leave the chip glitch-free.
module sram_port_arbiter #(
    parameter int unsigned BEAT_CYCLES = 2,
    parameter bit          PRIO_DATA   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] addr0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic [19:0] sram_adr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int unsigned      CNT_W    = $clog2(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    // Control state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;     // port being served
    logic               last_q, last_d;   // port served most recently
    logic               we_q, we_d;
    // Transaction data
    logic [18:0]        adr_q, adr_d;     // halfword-pair address, addr[20:2]
    logic [31:0]        wdata_q, wdata_d;
    logic [15:0]        hi_q, hi_d;       // upper read halfword from BEAT0
    logic [31:0]        rdata_q, rdata_d;
    // Registered pin/handshake outputs
    logic               ack0_q, ack0_d, ack1_q, ack1_d;
    logic [19:0]        sram_adr_q, sram_adr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic               beat_act;
    logic               grant1;
    logic               unused_addr_bits;

    // Only addr[20:2] selects the halfword pair; the rest is don't-care.
    assign unused_addr_bits = ^{addr0[31:21], addr0[1:0], addr1[31:21], addr1[1:0]};

    // Port 1 wins when alone, on fixed priority, or when port 0 was served last.
    assign grant1 = req1 && (!req0 || PRIO_DATA || !last_q);

    // Next-state: arbitration, beat sequencing and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = BEAT0;
                    cnt_d   = '0;
                    sel_d   = grant1;
                    we_d    = grant1 && we1;
                    adr_d   = grant1 ? addr1[20:2] : addr0[20:2];
                    wdata_d = grant1 ? wdata1 : wdata_q;
                end
            end
            BEAT0: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = BEAT1;
                    cnt_d   = '0;
                    if (!we_q) hi_d = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BEAT1: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    last_d  = sel_q;
                    if (!we_q) rdata_d = {hi_q, sram_dq_in};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values for the cycle being entered, derived from the next state.
    always_comb begin
        beat_act   = (state_d == BEAT0) || (state_d == BEAT1);
        ack0_d     = (state_d == DONE) && !sel_d;
        ack1_d     = (state_d == DONE) && sel_d;
        ce_n_d     = !beat_act;
        oe_n_d     = !(beat_act && !we_d);
        dq_oe_d    = beat_act && we_d;
        // Write strobe stays high in the first cycle of a beat while the address settles.
        we_n_d     = !(beat_act && we_d && (cnt_d != '0));
        sram_adr_d = beat_act ? {adr_d, state_d == BEAT1} : sram_adr_q;
        dq_out_d   = dq_oe_d ? ((state_d == BEAT1) ? wdata_d[15:0] : wdata_d[31:16])
                             : dq_out_q;
    end

    // Control and output registers; reset aborts any access with pins idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            sram_adr_q <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            sram_adr_q <= sram_adr_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
        end
    end

    // Transaction data registers need no reset; they are loaded before use.
    always_ff @(posedge clk) begin
        adr_q   <= adr_d;
        wdata_q <= wdata_d;
        hi_q    <= hi_d;
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata       = rdata_q;
    assign sram_adr    = sram_adr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ce_n_q;
    assign sram_lb_n   = ce_n_q;

endmodule
